// File: rtl/mem_load_align.sv
// Load-return stage: tracks loads through BRAM read latency, then lane-selects and extends doutB.
// Optional MEM_MISALIGN_TRAP_EN: misaligned loads retire on the misalign strobe instead of loadValid.
module mem_load_align #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic [31:0] addr,
  input  logic [1:0]  memOp,
  input  logic [1:0]  memSize,
  input  logic [4:0]  rd,
  input  logic        flush,
  input  logic [31:0] doutB,
  output logic [31:0] loadData,
  output logic [4:0]  loadRd,
  output logic        loadValid,
  output logic        misalign,
  output logic        busy
);

  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_WRITE     = 2'b11;
  localparam logic [1:0] BYTE          = 2'b00;
  localparam logic [1:0] HALFWORD      = 2'b01;
  localparam logic [1:0] WORD          = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [1:0] addrLo;
    logic       zext;
    logic [1:0] size;
    logic [4:0] rd;
  } tag_t;

  tag_t        tagPipe [READ_LATENCY];
  tag_t        newTag;
  tag_t        head;
  logic        retire;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] aligned;
  logic        unusedAddr;

  assign unusedAddr = ^addr[31:2];

  // Stores and no-ops never create a tag; memOp[1] distinguishes ZEXT from SEXT for loads.
  always_comb begin
    newTag.valid  = issue && (memOp == MEM_READ_SEXT || memOp == MEM_READ_ZEXT)
                    && memOp != MEM_DISABLE && memOp != MEM_WRITE;
    newTag.addrLo = addr[1:0];
    newTag.zext   = memOp[1];
    newTag.size   = memSize;
    newTag.rd     = rd;
  end

  // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
  // NOTE: only the valid bits need reset; the payload is ignored whenever valid is low.
  always_ff @(posedge clk) begin
    tagPipe[0] <= newTag;
    for (int i = 1; i < READ_LATENCY; i++) tagPipe[i] <= tagPipe[i-1];
    if (reset || flush) begin
      for (int i = 0; i < READ_LATENCY; i++) tagPipe[i].valid <= 1'b0;
    end
  end

  assign head   = tagPipe[READ_LATENCY-1];
  assign retire = head.valid && !flush;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    laneByte = doutB[7:0];
    laneHalf = head.addrLo[1] ? doutB[31:16] : doutB[15:0];
    aligned  = doutB;
    case (head.addrLo)
      2'd1:    laneByte = doutB[15:8];
      2'd2:    laneByte = doutB[23:16];
      2'd3:    laneByte = doutB[31:24];
      default: laneByte = doutB[7:0];
    endcase
    case (head.size)
      BYTE:        aligned = {{24{laneByte[7] & ~head.zext}}, laneByte};
      HALFWORD:    aligned = {{16{laneHalf[15] & ~head.zext}}, laneHalf};
      WORD, 2'b11: aligned = doutB;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (head.size == HALFWORD && head.addrLo[0])
                   || ((head.size == WORD || head.size == 2'b11) && head.addrLo != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      loadValid <= 1'b0;
      misalign  <= 1'b0;
      loadData  <= 32'h0;
      loadRd    <= 5'h0;
    end else begin
      loadValid <= retire && !misaligned;
      misalign  <= retire && misaligned;
      if (retire) begin
        loadData <= misaligned ? 32'h0 : aligned;
        loadRd   <= head.rd;
      end
    end
  end
`else
  assign misalign = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      loadValid <= 1'b0;
      loadData  <= 32'h0;
      loadRd    <= 5'h0;
    end else begin
      loadValid <= retire;
      if (retire) begin
        loadData <= aligned;
        loadRd   <= head.rd;
      end
    end
  end
`endif

  always_comb begin
    busy = loadValid;
    for (int i = 0; i < READ_LATENCY; i++) busy = busy | tagPipe[i].valid;
  end

endmodule

// File: tb/tb_mem_load_align.sv
// Scoreboard bench for mem_load_align at READ_LATENCY 1 and 2 side by side, fed from a small BRAM model.
// Expected values follow MEM_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_load_align;

  localparam logic [1:0] OP_DIS = 2'b00, OP_SEXT = 2'b01, OP_ZEXT = 2'b10, OP_ST = 2'b11;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

  typedef struct {
    int          due;
    logic        mis;
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, issue, flush;
  logic [31:0] addr;
  logic [1:0]  memOp, memSize;
  logic [4:0]  rd;
  logic [31:0] rdA, rdB;
  logic [31:0] ld0, ld1;
  logic [4:0]  lr0, lr1;
  logic        lv0, lv1, mi0, mi1, bz0, bz1;
  logic [31:0] mem [256];

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   started = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM port B model: one registered read, plus a second stage for the latency-2 instance.
  always @(posedge clk) begin
    rdA <= mem[addr[9:2]];
    rdB <= rdA;
  end

  mem_load_align #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .issue(issue), .addr(addr), .memOp(memOp), .memSize(memSize),
    .rd(rd), .flush(flush), .doutB(rdA), .loadData(ld0), .loadRd(lr0), .loadValid(lv0),
    .misalign(mi0), .busy(bz0));

  mem_load_align #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .issue(issue), .addr(addr), .memOp(memOp), .memSize(memSize),
    .rd(rd), .flush(flush), .doutB(rdB), .loadData(ld1), .loadRd(lr1), .loadValid(lv1),
    .misalign(mi1), .busy(bz1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit peek(input int lane, output exp_t e);
    e = '{0, 1'b0, 32'h0, 5'h0};
    if (lane == 0 && q0.size() > 0) begin e = q0[0]; return 1'b1; end
    if (lane == 1 && q1.size() > 0) begin e = q1[0]; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic popq(input int lane);
    if (lane == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic mon(input int lane, input logic v, input logic m, input logic [31:0] d,
                     input logic [4:0] r);
    exp_t e;
    bit   has;
    has = peek(lane, e);
    while (has && e.due < cyc) begin
      tests++;
      fails++;
      $display("FAIL L%0d missing: no result, expected data %h rd %0d at cycle %0d",
               lane, e.data, e.rd, e.due);
      popq(lane);
      has = peek(lane, e);
    end
    if (v !== 1'b0 || m !== 1'b0) begin
      if (!has) begin
        tests++;
        fails++;
        $display("FAIL L%0d unexpected strobe: valid=%b misalign=%b data=%h, expected none (cycle %0d)",
                 lane, v, m, d, cyc);
      end else begin
        popq(lane);
        check($sformatf("L%0d cycle", lane), cyc, e.due);
        check($sformatf("L%0d loadValid", lane), {31'h0, v}, {31'h0, ~e.mis});
        check($sformatf("L%0d misalign", lane), {31'h0, m}, {31'h0, e.mis});
        check($sformatf("L%0d loadData", lane), d, e.data);
        check($sformatf("L%0d loadRd", lane), {27'h0, r}, {27'h0, e.rd});
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      mon(0, lv0, mi0, ld0, lr0);
      mon(1, lv1, mi1, ld1, lr1);
    end
  end

  task automatic drive(input logic iss, input logic [1:0] op, input logic [1:0] sz,
                       input logic [31:0] a, input logic [4:0] r, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    issue = iss; memOp = op; memSize = sz; addr = a; rd = r; flush = fl; reset = rs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, OP_DIS, SZ_B, 32'h0, 5'h0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] a,
                      input logic [4:0] r, input logic [31:0] exp, input logic mis);
    drive(1'b1, op, sz, a, r, 1'b0, 1'b0);
    q0.push_back('{cyc + 2, mis, exp, r});
    q1.push_back('{cyc + 3, mis, exp, r});
  endtask

  // Misaligned loads: the trap build reports tag-only with zero data, otherwise truncated-address data.
  task automatic loadMis(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] a,
                         input logic [4:0] r, input logic [31:0] exp);
`ifdef MEM_MISALIGN_TRAP_EN
    load(op, sz, a, r, 32'h0, 1'b1);
`else
    load(op, sz, a, r, exp, 1'b0);
`endif
  endtask

  task automatic checkQuiet(input string tag);
    @(negedge clk);
    check({tag, " L0 loadValid"}, {31'h0, lv0}, 32'h0);
    check({tag, " L1 loadValid"}, {31'h0, lv1}, 32'h0);
    check({tag, " L0 misalign"},  {31'h0, mi0}, 32'h0);
    check({tag, " L1 misalign"},  {31'h0, mi1}, 32'h0);
    check({tag, " L0 busy"},      {31'h0, bz0}, 32'h0);
    check({tag, " L1 busy"},      {31'h0, bz1}, 32'h0);
    check({tag, " L0 loadData"},  ld0, 32'h0);
    check({tag, " L1 loadData"},  ld1, 32'h0);
    check({tag, " L0 loadRd"},    {27'h0, lr0}, 32'h0);
    check({tag, " L1 loadRd"},    {27'h0, lr1}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h8899AABB;
    mem[8'h41] = 32'h7F8001FE;
    reset = 1'b1; issue = 1'b0; flush = 1'b0; addr = 32'h0; memOp = OP_DIS; memSize = SZ_B; rd = 5'h0;

    repeat (3) drive(1'b0, OP_DIS, SZ_B, 32'h0, 5'h0, 1'b0, 1'b1);
    idle(1);
    started = 1;
    checkQuiet("reset");

    // Sign-extended top byte.
    load(OP_SEXT, SZ_B, 32'h103, 5'd5, 32'hFFFFFF88, 1'b0);
    idle(3);

    // Back-to-back loads from 0x8899AABB.
    load(OP_ZEXT, SZ_B, 32'h100, 5'd1, 32'h000000BB, 1'b0);
    load(OP_SEXT, SZ_H, 32'h102, 5'd2, 32'hFFFF8899, 1'b0);
    load(OP_ZEXT, SZ_H, 32'h100, 5'd3, 32'h0000AABB, 1'b0);
    load(OP_SEXT, SZ_W, 32'h100, 5'd4, 32'h8899AABB, 1'b0);
    idle(4);

    // Lanes and extension on 0x7F8001FE, plus the reserved size.
    load(OP_SEXT, SZ_B, 32'h104, 5'd6,  32'hFFFFFFFE, 1'b0);
    load(OP_ZEXT, SZ_B, 32'h105, 5'd7,  32'h00000001, 1'b0);
    load(OP_SEXT, SZ_B, 32'h106, 5'd8,  32'hFFFFFF80, 1'b0);
    load(OP_SEXT, SZ_H, 32'h106, 5'd9,  32'h00007F80, 1'b0);
    load(OP_ZEXT, SZ_H, 32'h104, 5'd10, 32'h000001FE, 1'b0);
    load(OP_SEXT, SZ_B, 32'h107, 5'd11, 32'h0000007F, 1'b0);
    load(OP_SEXT, SZ_R, 32'h104, 5'd12, 32'h7F8001FE, 1'b0);
    load(OP_ZEXT, SZ_H, 32'h102, 5'd13, 32'h00008899, 1'b0);
    idle(4);

    // Misaligned halfword and word loads.
    loadMis(OP_SEXT, SZ_H, 32'h101, 5'd14, 32'hFFFFAABB);
    loadMis(OP_SEXT, SZ_W, 32'h103, 5'd15, 32'h8899AABB);
    loadMis(OP_ZEXT, SZ_H, 32'h107, 5'd16, 32'h00007F80);
    load(OP_ZEXT, SZ_B, 32'h102, 5'd17, 32'h00000099, 1'b0);
    idle(4);

    // Store then load, and a MEM_DISABLE issue: only the load retires.
    drive(1'b1, OP_ST, SZ_W, 32'h100, 5'd20, 1'b0, 1'b0);
    load(OP_SEXT, SZ_W, 32'h104, 5'd18, 32'h7F8001FE, 1'b0);
    drive(1'b1, OP_DIS, SZ_W, 32'h100, 5'd21, 1'b0, 1'b0);
    idle(5);

    // Flush the cycle after issue, then a load issued together with flush.
    drive(1'b1, OP_ZEXT, SZ_B, 32'h101, 5'd22, 1'b0, 1'b0);
    drive(1'b0, OP_DIS, SZ_B, 32'h0, 5'h0, 1'b1, 1'b0);
    idle(1);
    @(negedge clk);
    check("flush L0 busy", {31'h0, bz0}, 32'h0);
    check("flush L1 busy", {31'h0, bz1}, 32'h0);
    drive(1'b1, OP_SEXT, SZ_W, 32'h100, 5'd23, 1'b1, 1'b0);
    idle(4);

    // Reset with an LW in flight and a load issued in the reset cycle.
    drive(1'b1, OP_SEXT, SZ_W, 32'h100, 5'd24, 1'b0, 1'b0);
    drive(1'b1, OP_SEXT, SZ_B, 32'h101, 5'd25, 1'b0, 1'b1);
    idle(1);
    checkQuiet("post-reset");
    idle(6);

    check("L0 queue drained", q0.size(), 32'h0);
    check("L1 queue drained", q1.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
